// File: rtl/scan_seq_pkg.sv
// Shared constants and state encoding for the channel scan sequencer.
package scan_seq_pkg;

    localparam int NCH_DEF = 16;
    localparam int DW_DEF  = 8;
    localparam int SCW_DEF = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ARM      = 3'd1;
    localparam state_t ST_DWELL    = 3'd2;
    localparam state_t ST_DUMP     = 3'd3;
    localparam state_t ST_SCAN_END = 3'd4;
    localparam state_t ST_GAP      = 3'd5;
    localparam state_t ST_ABORT    = 3'd6;

endpackage

// File: rtl/scan_seq_if.sv
// Control/strobe bundle between the register block, the sequencer
// and priority_fsm.
interface scan_seq_if #(
    parameter int NCH = 16,
    parameter int DW  = 8,
    parameter int SCW = 16
);
    logic           start_i;
    logic           stop_i;
    logic           continuous_i;
    logic [NCH-1:0] mask_i;
    logic [DW-1:0]  dwell_i;
    logic [DW-1:0]  gap_i;
    logic           cycle_done_i;
    logic           arm_o;
    logic           dump_o;
    logic           inter_o;
    logic           disable_o;
    logic [NCH-1:0] ch_sel_o;
    logic           busy_o;
    logic           done_o;
    logic           err_o;
    logic [SCW-1:0] scan_cnt_o;

    modport master (
        output start_i, stop_i, continuous_i, mask_i,
        output dwell_i, gap_i, cycle_done_i,
        input  arm_o, dump_o, inter_o, disable_o,
        input  ch_sel_o, busy_o, done_o, err_o, scan_cnt_o
    );

    modport slave (
        input  start_i, stop_i, continuous_i, mask_i,
        input  dwell_i, gap_i, cycle_done_i,
        output arm_o, dump_o, inter_o, disable_o,
        output ch_sel_o, busy_o, done_o, err_o, scan_cnt_o
    );
endinterface

// File: rtl/scan_sequencer_timer.sv
// Loadable down-counter; expire_o marks the last cycle of a count.
module scan_timer #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [DW-1:0] val_i,
    output logic          expire_o
);
    logic [DW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= val_i;
        end else if (en_i && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire_o = (cnt <= DW'(1));
endmodule

// File: rtl/scan_sequencer.sv
// Autonomous channel-mask scanner driving priority_fsm strobes,
// with continuous mode, inter-scan gap, abort and dump watchdog.
module scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int DW  = DW_DEF,
    parameter int SCW = SCW_DEF
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    scan_seq_if.slave  bus
);
    localparam int CW = $clog2(NCH + 1);

    state_t         st;
    state_t         nx;
    logic [DW-1:0]  dwell_q;
    logic [DW-1:0]  gap_q;
    logic [DW-1:0]  dwell_eff;
    logic [CW-1:0]  dump_cnt;
    logic [NCH-1:0] ch_sel;
    logic [SCW-1:0] scan_cnt;
    logic           done_q;
    logic           done_seen;
    logic           err_q;
    logic           err_d;
    logic           rearm;
    logic           dw_exp;
    logic           gp_exp;

    assign dwell_eff = (dwell_q == '0) ? DW'(1) : dwell_q;
    // cycle_done in the expiring cycle itself still counts
    assign done_seen = done_q | (bus.cycle_done_i && dump_cnt != '0);

    always_comb begin
        nx    = st;
        err_d = 1'b0;
        rearm = 1'b0;
        unique case (st)
            ST_IDLE: begin
                if (bus.start_i) begin
                    if (bus.mask_i != '0) nx = ST_ARM;
                    else err_d = 1'b1;
                end
            end
            ST_ARM:  nx = ST_DWELL;
            ST_DWELL: begin
                if (dw_exp) begin
                    if (dump_cnt != '0 && done_seen) begin
                        nx = ST_SCAN_END;
                    end else if (dump_cnt == CW'(NCH)) begin
                        nx    = ST_ABORT;
                        err_d = 1'b1;
                    end else begin
                        nx = ST_DUMP;
                    end
                end
            end
            ST_DUMP: nx = ST_DWELL;
            ST_SCAN_END: begin
                if (!bus.continuous_i) nx = ST_IDLE;
                else if (gap_q != '0) nx = ST_GAP;
                else rearm = 1'b1;
            end
            ST_GAP:   rearm = gp_exp;
            ST_ABORT: nx = ST_IDLE;
            default:  nx = ST_IDLE;
        endcase
        if (rearm) begin
            if (bus.mask_i != '0) begin
                nx = ST_ARM;
            end else begin
                nx    = ST_IDLE;
                err_d = 1'b1;
            end
        end
        if (bus.stop_i && st != ST_IDLE && st != ST_ABORT) begin
            nx    = ST_ABORT;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            st       <= ST_IDLE;
            dwell_q  <= '0;
            gap_q    <= '0;
            dump_cnt <= '0;
            ch_sel   <= '0;
            scan_cnt <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            st    <= nx;
            err_q <= err_d;
            if (st == ST_IDLE && nx == ST_ARM) begin
                dwell_q <= bus.dwell_i;
                gap_q   <= bus.gap_i;
            end
            if (nx == ST_ARM) begin
                ch_sel   <= bus.mask_i;
                dump_cnt <= '0;
                done_q   <= 1'b0;
            end else begin
                if (st == ST_DUMP) dump_cnt <= dump_cnt + 1'b1;
                if (done_seen) done_q <= 1'b1;
            end
            if (st == ST_SCAN_END) scan_cnt <= scan_cnt + 1'b1;
        end
    end

    scan_timer #(.DW(DW)) u_dwell (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .load_i   (st == ST_ARM || st == ST_DUMP),
        .en_i     (st == ST_DWELL),
        .val_i    (dwell_eff),
        .expire_o (dw_exp)
    );

    scan_timer #(.DW(DW)) u_gap (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .load_i   (st == ST_SCAN_END),
        .en_i     (st == ST_GAP),
        .val_i    (gap_q),
        .expire_o (gp_exp)
    );

    assign bus.arm_o      = (st == ST_ARM);
    assign bus.dump_o     = (st == ST_DUMP);
    assign bus.inter_o    = (st == ST_ABORT);
    assign bus.disable_o  = (st == ST_IDLE);
    assign bus.busy_o     = (st != ST_IDLE);
    assign bus.done_o     = (st == ST_SCAN_END);
    assign bus.err_o      = err_q;
    assign bus.ch_sel_o   = ch_sel;
    assign bus.scan_cnt_o = scan_cnt;
endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: directed and random scans against an
// arithmetic event-schedule model plus a stand-in priority_fsm.
module tb_scan_sequencer;
    localparam int NCH = 16;
    localparam int DW  = 8;
    localparam int SCW = 16;

    typedef int iq_t[$];

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    scan_seq_if #(.NCH(NCH), .DW(DW), .SCW(SCW)) bus();

    scan_sequencer #(.NCH(NCH), .DW(DW), .SCW(SCW)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tbase  = 0;
    int busy_n = 0;
    int exp_cnt = 0;
    iq_t arm_q, dump_q, done_q, err_q, inter_q;
    iq_t e_arm, e_dump, e_done, e_err, e_inter;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in priority_fsm: cycle_done one cycle after the dump
    // that has visited every selected channel.
    logic pf_en = 1'b1;
    int   pf_cnt = 0;
    always @(posedge clk) begin
        if (bus.arm_o) pf_cnt <= 0;
        else if (bus.dump_o) pf_cnt <= pf_cnt + 1;
        bus.cycle_done_i <= pf_en && bus.dump_o && !bus.arm_o &&
                            (pf_cnt + 1 == $countones(bus.ch_sel_o));
    end

    always @(negedge clk) begin
        if (bus.arm_o)   arm_q.push_back(cyc - tbase);
        if (bus.dump_o)  dump_q.push_back(cyc - tbase);
        if (bus.done_o)  done_q.push_back(cyc - tbase);
        if (bus.err_o)   err_q.push_back(cyc - tbase);
        if (bus.inter_o) inter_q.push_back(cyc - tbase);
        if (bus.busy_o)  busy_n++;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_q(string tag, iq_t got, iq_t exp);
        chk({tag, ".count"}, got.size(), exp.size());
        foreach (exp[i])
            if (i < got.size())
                chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic at(int t);
        int guard = 0;
        while (cyc - tbase < t && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic go(logic [NCH-1:0] m, logic [DW-1:0] d,
                      logic [DW-1:0] g, logic c);
        @(negedge clk);
        bus.mask_i       = m;
        bus.dwell_i      = d;
        bus.gap_i        = g;
        bus.continuous_i = c;
        bus.start_i      = 1'b1;
        tbase  = cyc;
        busy_n = 0;
        arm_q.delete(); dump_q.delete(); done_q.delete();
        err_q.delete(); inter_q.delete();
        e_arm.delete(); e_dump.delete(); e_done.delete();
        e_err.delete(); e_inter.delete();
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Expected schedule: dump k lands k*(D+1) after arm, done one
    // dwell period after the dump that completes the channel set.
    task automatic add_scan(int arm_t, int d, int n, output int done_t);
        e_arm.push_back(arm_t);
        for (int k = 1; k <= n; k++) e_dump.push_back(arm_t + k * (d + 1));
        done_t = arm_t + (n + 1) * (d + 1);
        e_done.push_back(done_t);
    endtask

    task automatic verify(string tag, int busy_exp);
        chk_q({tag, ".arm"},   arm_q,   e_arm);
        chk_q({tag, ".dump"},  dump_q,  e_dump);
        chk_q({tag, ".done"},  done_q,  e_done);
        chk_q({tag, ".err"},   err_q,   e_err);
        chk_q({tag, ".inter"}, inter_q, e_inter);
        chk({tag, ".busy_cycles"}, busy_n, busy_exp);
        chk({tag, ".scan_cnt"}, bus.scan_cnt_o, exp_cnt);
        chk({tag, ".disable"}, bus.disable_o, 1'b1);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, ".arm"},      bus.arm_o, 1'b0);
        chk({tag, ".dump"},     bus.dump_o, 1'b0);
        chk({tag, ".inter"},    bus.inter_o, 1'b0);
        chk({tag, ".disable"},  bus.disable_o, 1'b1);
        chk({tag, ".busy"},     bus.busy_o, 1'b0);
        chk({tag, ".done"},     bus.done_o, 1'b0);
        chk({tag, ".err"},      bus.err_o, 1'b0);
        chk({tag, ".ch_sel"},   bus.ch_sel_o, '0);
        chk({tag, ".scan_cnt"}, bus.scan_cnt_o, '0);
    endtask

    initial begin
        int t, d, n, g, m;
        logic c;

        resetn           = 1'b0;
        bus.start_i      = 1'b0;
        bus.stop_i       = 1'b0;
        bus.continuous_i = 1'b0;
        bus.mask_i       = '0;
        bus.dwell_i      = '0;
        bus.gap_i        = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        resetn = 1'b1;

        // Single shot, two channels, dwell 2
        go(16'h0022, 8'd2, 8'd0, 1'b0);
        add_scan(1, 2, 2, t);
        at(14);
        exp_cnt = 1;
        verify("single", 10);
        chk("single.ch_sel", bus.ch_sel_o, 16'h0022);

        // Empty mask
        go(16'h0000, 8'd3, 8'd0, 1'b0);
        e_err.push_back(1);
        at(6);
        verify("empty", 0);

        // Abort mid-dwell of the second dump
        go(16'h0022, 8'd2, 8'd0, 1'b0);
        at(5);
        bus.stop_i = 1'b1;
        at(6);
        bus.stop_i = 1'b0;
        e_arm.push_back(1);
        e_dump.push_back(4);
        e_inter.push_back(6);
        at(10);
        verify("stop", 6);

        // Watchdog: priority_fsm never reports cycle_done
        pf_en = 1'b0;
        go(16'h0001, 8'd1, 8'd0, 1'b0);
        e_arm.push_back(1);
        for (int k = 1; k <= NCH; k++) e_dump.push_back(1 + 2 * k);
        e_err.push_back(35);
        e_inter.push_back(35);
        at(40);
        verify("watchdog", 35);
        pf_en = 1'b1;

        // Random single-shot and two-scan continuous runs
        for (int i = 0; i < 8; i++) begin
            m = $urandom_range(1, 16'hFFFF);
            d = $urandom_range(0, 4);
            g = $urandom_range(0, 3);
            c = 1'($urandom_range(0, 1));
            n = $countones(m);
            go(m[NCH-1:0], d[DW-1:0], g[DW-1:0], c);
            if (d == 0) d = 1;
            add_scan(1, d, n, t);
            exp_cnt++;
            if (c) begin
                at(t + 1);
                bus.continuous_i = 1'b0;
                add_scan(t + 1 + g, d, n, t);
                exp_cnt++;
            end
            at(t + 4);
            verify($sformatf("rand%0d", i), t);
        end

        // Continuous with a mask change in the gap, then reset mid-scan
        go(16'hF040, 8'd1, 8'd3, 1'b1);
        at(14);
        chk("cont.cnt1", bus.scan_cnt_o, exp_cnt + 1);
        bus.mask_i = 16'h0001;
        at(17);
        chk("cont.ch_sel", bus.ch_sel_o, 16'h0001);
        at(22);
        chk("cont.cnt2", bus.scan_cnt_o, exp_cnt + 2);
        at(30);
        chk("cont.cnt3", bus.scan_cnt_o, exp_cnt + 3);
        at(34);
        resetn = 1'b0;
        at(35);
        chk_reset_vals("midreset");
        resetn = 1'b1;
        bus.continuous_i = 1'b0;
        add_scan(1, 1, 5, t);
        add_scan(17, 1, 1, t);
        add_scan(25, 1, 1, t);
        e_done.pop_back();
        e_done.push_back(t);
        e_arm.push_back(33);
        exp_cnt = 0;
        at(40);
        verify("cont", 34);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Controller that drives priority_fsm's arm/dump/inter/disable strobes so that a channel mask is scanned autonomously, one channel per dump, at a programmable dwell rate. It sits between the register/control interface and priority_fsm. It supports single-shot or continuous scans with a programmable inter-scan gap, and a software abort. A watchdog catches a missing cycle_done from the priority FSM.

Parameters:
NCH, 16, number of channels (width of mask and ch_sel).
DW, 8, width of the dwell and gap counters.
SCW, 16, width of the completed-scan counter.

Ports:
clk_i  in  1  clock, rising edge.
resetn_i  in  1  reset; synchronous, active-low.
start_i  in  1  start pulse; accepted only in IDLE.
stop_i  in  1  abort pulse; accepted only outside IDLE.
continuous_i  in  1  repeat scans until stop; sampled at SCAN_END.
mask_i  in  NCH  channel mask; latched at each ARM.
dwell_i  in  DW  cycles between strobes; latched at start; 0 treated as 1.
gap_i  in  DW  idle cycles between continuous scans; latched at start.
cycle_done_i  in  1  from priority_fsm cycle_done_o.
arm_o  out  1  to priority_fsm arm_i.
dump_o  out  1  to priority_fsm dump_i.
inter_o  out  1  to priority_fsm inter_i.
disable_o  out  1  to priority_fsm disable_i.
ch_sel_o  out  NCH  latched mask, to priority_fsm ch_sel_i.
busy_o  out  1  high in every state except IDLE.
done_o  out  1  one-cycle pulse at SCAN_END.
err_o  out  1  one-cycle pulse on empty-mask start or watchdog trip.
scan_cnt_o  out  SCW  completed scans; wraps modulo 2^SCW.

Behaviour:
- States: IDLE, ARM, DWELL, DUMP, SCAN_END, GAP, ABORT. All strobes are decoded from the registered state, so each strobe is one cycle wide.
- Reset values: state IDLE, disable_o=1, all other outputs 0, ch_sel_o=0, scan_cnt_o=0, internal counters and flags 0. Reset mid-scan returns to these values at the next edge. No inter_o is issued on reset.
- IDLE: disable_o=1.
  - start_i with mask_i!=0: latch dwell and gap, go ARM.
  - start_i with mask_i==0: err_o=1 in the next cycle, stay IDLE.
  - stop_i is ignored in IDLE. If start_i and stop_i arrive together in IDLE, start wins.
- ARM: arm_o=1; ch_sel_o<=mask_i; dump_cnt<=0; done flag cleared; dwell counter loaded with D=max(dwell,1). Next state DWELL.
- DWELL: counter decrements each cycle; state lasts exactly D cycles. On expiry:
  - if dump_cnt>0 and done flag set -> SCAN_END;
  - else if dump_cnt==NCH -> err_o pulse, go ABORT (watchdog);
  - else -> DUMP.
- DUMP: dump_o=1, dump_cnt++, reload the dwell counter, go DWELL.
- Timing: start sampled at cycle 0 -> arm_o at cycle 1, first dump_o at cycle 2+D. Subsequent dumps follow every D+1 cycles.
- Done flag: sticky. Set by cycle_done_i=1 in any cycle after the first DUMP; cleared only in ARM.
- SCAN_END: done_o=1, scan_cnt_o++.
  - continuous_i=1 and gap>0 -> GAP (gap cycles);
  - continuous_i=1 and gap==0 -> ARM directly;
  - otherwise -> IDLE.
- GAP: counts down; on expiry go ARM. The new mask_i is picked up at that ARM. If mask_i==0 at a continuous re-ARM: err_o pulse, go IDLE, no arm_o.
- stop_i in ARM/DWELL/DUMP/GAP/SCAN_END: go ABORT at the next edge. No further arm/dump, no done_o, scan_cnt unchanged. stop_i in SCAN_END suppresses the re-arm, but that scan's done_o and count still occur.
- ABORT: inter_o=1 for one cycle, then IDLE.
- start_i outside IDLE is ignored.
- Counter arithmetic is unsigned; dump_cnt is $clog2(NCH+1) bits.

Decomposition:
- Package scan_seq_pkg: state enum typedef, default NCH/DW/SCW constants.
- One sub-module, scan_timer: loadable DW-bit down-counter with an expire flag. Two instances, for dwell and gap.

Test Plan:
- Reset, mask 0x0022, dwell 2, single-shot, bench priority_fsm instance -> arm_o at cycle 1, dump_o at cycles 4 and 7, done_o at cycle 10, busy_o low at cycle 11, scan_cnt_o=1.
- start with mask 0x0000 -> err_o high at cycle 1 only; no arm_o; busy_o stays 0.
- Continuous, mask 0xF040, dwell 1, gap 3 -> 5 dumps per scan 2 cycles apart; 3-cycle gap then arm_o again; mask changed to 0x0001 during the gap yields ch_sel_o=0x0001 and 1 dump next scan; scan_cnt_o counts 1, 2, ...
- stop_i mid-DWELL of the second dump -> inter_o pulse next cycle, then IDLE with disable_o=1; no done_o; scan_cnt_o unchanged.
- cycle_done_i tied 0, mask 0x0001, dwell 1 -> exactly 16 dump_o pulses, then err_o and inter_o, then IDLE.
- resetn_i low for one cycle mid-scan with scan_cnt_o=3 -> next edge: all outputs at reset values, scan_cnt_o=0, no inter_o.
